// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues imem reads at pc, holds one fetched
// instruction in the IF/ID slot and computes the next PC (sequential, branch, jump).
module instr_fetch #(
  parameter int IMEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_en,
  input  logic [15:0] branch_offset,
  input  logic        jump_en,
  input  logic [25:0] jump_index,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, ERR} state_t;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_inc;
  logic        consume;
  logic        redirect;
  logic        accept;
  logic        misaligned;
  logic        timeout;
  logic [31:0] jmp_target;
  logic [31:0] br_target;

  assign consume    = if_valid && !stall;
  assign redirect   = consume && (jump_en || branch_en);
  assign misaligned = (pc[1:0] != 2'b00);
  assign imem_addr  = pc;
  // A misaligned pc never reaches memory; the FSM drops to ERR instead.
  assign imem_req   = !reset && (state == REQ) && !misaligned && (!if_valid || !stall);
  assign accept     = imem_req && imem_ack && !redirect;
  assign wait_inc   = wait_cnt + 8'd1;
  assign timeout    = imem_req && !imem_ack && !redirect && (wait_inc == 8'(IMEM_TIMEOUT));

  assign jmp_target = {if_pc4[31:28], jump_index, 2'b00};
  assign br_target  = if_pc4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};

  always_comb begin
    pc_next = pc;
    if (reset)
      pc_next = 32'd0;
    else if (redirect)
      pc_next = jump_en ? jmp_target : br_target;
    else if (accept)
      pc_next = pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      if_valid  <= 1'b0;
      if_instr  <= 32'd0;
      if_pc4    <= 32'd0;
      fetch_err <= 1'b0;
      wait_cnt  <= 8'd0;
    end else if (redirect) begin
      // Redirect wins over a same-cycle ack and is the only way out of ERR.
      if_valid <= 1'b0;
      wait_cnt <= 8'd0;
      state    <= REQ;
    end else begin
      if (accept) begin
        if_instr <= imem_rdata;
        if_pc4   <= pc + 32'd4;
        if_valid <= 1'b1;
        wait_cnt <= 8'd0;
      end else begin
        if (consume)
          if_valid <= 1'b0;
        if (imem_req && !imem_ack)
          wait_cnt <= wait_inc;
      end
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (misaligned || timeout) begin
            state     <= ERR;
            fetch_err <= 1'b1;
          end
        end
        default: state <= ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a vector table for the main fetch/stall/redirect
// flow, then hand sequences for mid-request reset, timeout and misaligned-PC error.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_en;
  logic [15:0] branch_offset;
  logic        jump_en;
  logic [25:0] jump_index;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch #(.IMEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .stall(stall), .branch_en(branch_en),
    .branch_offset(branch_offset), .jump_en(jump_en), .jump_index(jump_index),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc4(if_pc4), .fetch_err(fetch_err)
  );

  typedef struct {
    logic        setpc;
    logic [31:0] pcv;
    logic        rst;
    logic        stl;
    logic        ack;
    logic [31:0] rdata;
    logic        br;
    logic [15:0] off;
    logic        jmp;
    logic [25:0] idx;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_pcn;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // PC register model: latch pc_next at the edge, applied just after it.
  task automatic step();
    logic [31:0] pn;
    pn = pc_next;
    @(posedge clk);
    #1;
    pc = pn;
  endtask

  task automatic idle_inputs();
    stall = 0; imem_ack = 0; imem_rdata = 32'd0; branch_en = 0;
    branch_offset = 16'd0; jump_en = 0; jump_index = 26'd0;
  endtask

  initial begin
    int nreq;
    vecs[0]  = '{0, 0, 1, 0, 0, 32'h0,        0, 16'h0,    0, 26'h0,  0, 32'h40,       32'h0,        0, 32'h0,        32'h0};
    vecs[1]  = '{0, 0, 0, 0, 1, 32'h20080005, 0, 16'h0,    0, 26'h0,  0, 32'h0,        32'h0,        0, 32'h0,        32'h0};
    vecs[2]  = '{0, 0, 0, 0, 1, 32'h20080005, 0, 16'h0,    0, 26'h0,  1, 32'h0,        32'h4,        1, 32'h20080005, 32'h4};
    vecs[3]  = '{0, 0, 0, 0, 1, 32'h11111111, 0, 16'h0,    0, 26'h0,  1, 32'h4,        32'h8,        1, 32'h11111111, 32'h8};
    vecs[4]  = '{0, 0, 0, 0, 1, 32'h22222222, 0, 16'h0,    0, 26'h0,  1, 32'h8,        32'hC,        1, 32'h22222222, 32'hC};
    vecs[5]  = '{0, 0, 0, 1, 1, 32'h33333333, 0, 16'h0,    0, 26'h0,  0, 32'hC,        32'hC,        1, 32'h22222222, 32'hC};
    vecs[6]  = '{0, 0, 0, 1, 1, 32'h33333333, 0, 16'h0,    0, 26'h0,  0, 32'hC,        32'hC,        1, 32'h22222222, 32'hC};
    vecs[7]  = '{0, 0, 0, 1, 1, 32'h33333333, 0, 16'h0,    0, 26'h0,  0, 32'hC,        32'hC,        1, 32'h22222222, 32'hC};
    vecs[8]  = '{0, 0, 0, 0, 1, 32'h44444444, 0, 16'h0,    0, 26'h0,  1, 32'hC,        32'h10,       1, 32'h44444444, 32'h10};
    vecs[9]  = '{0, 0, 0, 0, 1, 32'h55555555, 1, 16'hFFFC, 0, 26'h0,  1, 32'h10,       32'h0,        0, 32'h44444444, 32'h10};
    vecs[10] = '{0, 0, 0, 0, 1, 32'h66666666, 0, 16'h0,    0, 26'h0,  1, 32'h0,        32'h4,        1, 32'h66666666, 32'h4};
    vecs[11] = '{1, 32'h10000004, 0, 0, 1, 32'h77777777, 0, 16'h0, 0, 26'h0, 1, 32'h10000004, 32'h10000008, 1, 32'h77777777, 32'h10000008};
    vecs[12] = '{0, 0, 0, 0, 1, 32'h88888888, 1, 16'h0004, 1, 26'h40, 1, 32'h10000008, 32'h10000100, 0, 32'h77777777, 32'h10000008};
    vecs[13] = '{0, 0, 0, 0, 0, 32'h0,        1, 16'h0004, 0, 26'h0,  1, 32'h10000100, 32'h10000100, 0, 32'h77777777, 32'h10000008};
    vecs[14] = '{0, 0, 0, 0, 1, 32'h99999999, 0, 16'h0,    0, 26'h0,  1, 32'h10000100, 32'h10000104, 1, 32'h99999999, 32'h10000104};
    vecs[15] = '{0, 0, 0, 1, 1, 32'hAAAAAAAA, 0, 16'h0,    1, 26'h5,  0, 32'h10000104, 32'h10000104, 1, 32'h99999999, 32'h10000104};
    vecs[16] = '{0, 0, 0, 0, 0, 32'h0,        0, 16'h0,    0, 26'h0,  1, 32'h10000104, 32'h10000104, 0, 32'h99999999, 32'h10000104};

    pc = 32'h40;
    reset = 1;
    idle_inputs();

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].setpc) pc = vecs[i].pcv;
      reset = vecs[i].rst; stall = vecs[i].stl; imem_ack = vecs[i].ack;
      imem_rdata = vecs[i].rdata; branch_en = vecs[i].br; branch_offset = vecs[i].off;
      jump_en = vecs[i].jmp; jump_index = vecs[i].idx;
      #1;
      chk($sformatf("v%0d imem_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
      chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d pc_next", i), pc_next, vecs[i].exp_pcn);
      step();
      chk($sformatf("v%0d if_valid", i), 32'(if_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d if_instr", i), if_instr, vecs[i].exp_instr);
      chk($sformatf("v%0d if_pc4", i), if_pc4, vecs[i].exp_pc4);
      chk($sformatf("v%0d fetch_err", i), 32'(fetch_err), 32'd0);
      $display("vec %0d: pc_next=%h req=%b valid=%b instr=%h pc4=%h", i, pc_next, imem_req, if_valid, if_instr, if_pc4);
    end

    // Reset arriving during the 5th wait cycle of an outstanding request.
    reset = 1; idle_inputs(); step();
    reset = 0; imem_ack = 1; imem_rdata = 32'hABCD1234; step(); step();
    chk("mid-rst preload instr", if_instr, 32'hABCD1234);
    imem_ack = 0;
    for (int i = 0; i < 4; i++) step();
    #1;
    chk("mid-rst 5th wait req", 32'(imem_req), 32'd1);
    reset = 1;
    #1;
    chk("in-reset imem_req", 32'(imem_req), 32'd0);
    chk("in-reset pc_next", pc_next, 32'd0);
    step();
    chk("post-rst if_valid", 32'(if_valid), 32'd0);
    chk("post-rst if_instr", if_instr, 32'd0);
    chk("post-rst if_pc4", if_pc4, 32'd0);
    chk("post-rst fetch_err", 32'(fetch_err), 32'd0);
    $display("mid-request reset: valid=%b instr=%h pc4=%h err=%b", if_valid, if_instr, if_pc4, fetch_err);
    reset = 0; imem_ack = 1; imem_rdata = 32'h0BADF00D; step();
    #1;
    chk("refetch req", 32'(imem_req), 32'd1);
    chk("refetch addr", imem_addr, 32'd0);
    step();
    chk("refetch instr", if_instr, 32'h0BADF00D);
    chk("refetch pc4", if_pc4, 32'h4);
    $display("refetch after reset: instr=%h pc4=%h", if_instr, if_pc4);

    // Timeout with the ack held low; the wait counter must have restarted at reset.
    imem_ack = 0;
    nreq = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (imem_req) nreq++;
      step();
      if (fetch_err) break;
    end
    chk("timeout request cycles", 32'(nreq), 32'd15);
    chk("timeout fetch_err", 32'(fetch_err), 32'd1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("err req low %0d", i), 32'(imem_req), 32'd0);
      chk($sformatf("err pc hold %0d", i), pc_next, pc);
      step();
    end
    $display("timeout: request cycles=%0d fetch_err=%b", nreq, fetch_err);

    // Misaligned pc with a held slot, then a jump out of ERR.
    reset = 1; idle_inputs(); step();
    reset = 0; step();
    imem_ack = 1; imem_rdata = 32'hC0DE0001; step();
    chk("mis preload valid", 32'(if_valid), 32'd1);
    stall = 1; imem_ack = 0; pc = 32'h2;
    #1;
    chk("mis req", 32'(imem_req), 32'd0);
    step();
    chk("mis fetch_err", 32'(fetch_err), 32'd1);
    chk("mis slot held", 32'(if_valid), 32'd1);
    stall = 0; jump_en = 1; jump_index = 26'h10;
    #1;
    chk("err jump pc_next", pc_next, 32'h40);
    step();
    chk("err jump valid", 32'(if_valid), 32'd0);
    jump_en = 0; imem_ack = 1; imem_rdata = 32'h12345678;
    #1;
    chk("restart req", 32'(imem_req), 32'd1);
    chk("restart addr", imem_addr, 32'h40);
    step();
    chk("restart instr", if_instr, 32'h12345678);
    chk("restart err sticky", 32'(fetch_err), 32'd1);
    $display("redirect from ERR: instr=%h pc4=%h err=%b", if_instr, if_pc4, fetch_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter IMEM_TIMEOUT, default 15, SHALL set the number of consecutive un-acked request cycles that trigger a fetch error (legal range 1..255).
REQ-002 clk  input  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 pc  input  32  SHALL carry the current program counter from the PC register.
REQ-005 pc_next  output  32  SHALL drive the PC register input, combinationally.
REQ-006 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-007 imem_addr  output  32  SHALL be the read address.
REQ-008 imem_ack  input  1  SHALL indicate that imem_rdata is valid.
REQ-009 imem_rdata  input  32  SHALL carry the instruction word.
REQ-010 stall  input  1  SHALL mean that decode cannot accept the held instruction this cycle.
REQ-011 branch_en  input  1  SHALL mean that the held instruction's branch is taken.
REQ-012 branch_offset  input  16  SHALL be the signed word offset of that branch.
REQ-013 jump_en  input  1  SHALL mean that the held instruction is a jump.
REQ-014 jump_index  input  26  SHALL be the jump instr_index field.
REQ-015 if_valid  output  1  SHALL mean that the IF/ID slot holds an instruction.
REQ-016 if_instr  output  32  SHALL be the held instruction.
REQ-017 if_pc4  output  32  SHALL be the held instruction's address + 4.
REQ-018 fetch_err  output  1  SHALL be a sticky fetch-error flag.

Function
REQ-019 The FSM SHALL have three states: IDLE, REQ and ERR.
REQ-020 The FSM SHALL go IDLE->REQ on the first cycle after reset deasserts.
REQ-021 imem_addr SHALL equal pc at all times.
REQ-022 imem_req SHALL equal (state==REQ) && (!if_valid || !stall).
REQ-023 imem_ack SHALL be ignored when imem_req=0.
REQ-024 Accepted ack (imem_req && imem_ack, no redirect): if_instr<=imem_rdata, if_pc4<=pc+4 (mod 2^32), if_valid<=1, pc_next=pc+4.
REQ-025 Slot consumed (if_valid && !stall) with no accepted ack: if_valid<=0.
REQ-026 Default: pc_next SHALL equal pc, so the PC holds.
REQ-027 Redirect SHALL be jump_en||branch_en, honoured only when if_valid=1 and stall=0; both ignored otherwise.
REQ-028 Jump SHALL have priority over branch: pc_next = {if_pc4[31:28], jump_index, 2'b00}.
REQ-029 Branch target: pc_next = if_pc4 + (sign-extended branch_offset << 2), mod 2^32.
REQ-030 On redirect: if_valid<=0, any same-cycle ack discarded, wait counter cleared, state<=REQ (including from ERR).
REQ-031 An 8-bit wait counter SHALL increment each cycle with imem_req=1 and imem_ack=0, and clear on an accepted ack or a redirect.
REQ-032 When the counter reaches IMEM_TIMEOUT: state<=ERR, fetch_err<=1.
REQ-033 A REQ-state cycle with pc[1:0]!=0 SHALL go to ERR with fetch_err<=1 and no request issued.
REQ-034 In ERR: imem_req=0, pc_next=pc, if_valid<=0 once the slot is consumed.
REQ-035 ERR SHALL exit only via reset or redirect; fetch_err SHALL clear only on reset.
REQ-036 Latency: instruction visible in if_instr on the edge after its ack; with continuous ack and no stall, throughput SHALL be one instruction per cycle.

Reset
REQ-037 reset SHALL override all other inputs, including mid-request.
REQ-038 Reset values: state IDLE, if_valid 0, if_instr 0, if_pc4 0, fetch_err 0, wait counter 0.
REQ-039 While reset=1: imem_req=0 and pc_next=0.

Verification
REQ-040 Reset, then ack every cycle with rdata=0x20080005 -> imem_addr 0x0,0x4,0x8; if_pc4 0x4,0x8,0xC; if_valid=1 from the 2nd post-reset edge.
REQ-041 if_valid=1, stall=1 for 3 cycles, ack held high -> imem_req=0, if_instr unchanged, pc_next=pc; the fetch resumes the cycle stall drops.
REQ-042 if_pc4=0x00000010, branch_en=1, branch_offset=0xFFFC -> pc_next=0x00000000, the same-cycle ack is discarded, and if_valid=0 after the edge.
REQ-043 jump_en=1 and branch_en=1, if_pc4=0x10000008, jump_index=0x0000040 -> pc_next=0x10000100.
REQ-044 Ack never asserted, IMEM_TIMEOUT=15 -> fetch_err=1 after the 15th request cycle, imem_req=0 thereafter; a redirect restarts fetch with fetch_err still 1.
REQ-045 reset asserted during the 5th wait cycle -> all outputs at reset values on the next edge; a fresh fetch of 0x0 follows.
